ap_host_sequencer: RTL and testbench
====================================

// Module: ap_host_sequencer
// PURPOSE
//  Initiator for the AP wrapper memory-mapped request interface. Accepts one job
//  (cmd, direction, target, element count), streams operand pairs into CAM A/B,
//  programs the mode/control settings words, triggers the AP, polls state_irq and
//  drains CAM C results to an output stream. Sits between a host DMA/stream and the AP.
// PARAMETERS
//  WORD_SIZE     8      operand/result width in bits
//  CELL_QUANT    128    cells per CAM column; max job count
//  POLL_TIMEOUT  4096   POLL-state cycles before timeout_err
// PORTS  (AW = clog2(CELL_QUANT*6); CW = clog2(CELL_QUANT+1))
//  clock              in   1          clock
//  reset              in   1          synchronous, active-high
//  start              in   1          job start pulse; sampled only in IDLE
//  job_cmd            in   3          AP command (mode word byte0)
//  job_dir            in   1          0 vertical / 1 horizontal (mode word byte1)
//  job_target         in   1          0 -> C, 1 -> A (ctrl word byte2)
//  job_count          in   CW         elements, 1..CELL_QUANT
//  busy               out  1          high from start accept until DONE exits
//  done               out  1          1-cycle pulse on job completion
//  timeout_err        out  1          sticky; set on poll timeout, cleared by start
//  in_valid/in_ready  in/out 1        operand stream handshake
//  in_data            in   2*WORD_SIZE {b, a}; a = [WORD_SIZE-1:0]
//  out_valid/out_ready out/in 1       result stream handshake
//  out_data           out  WORD_SIZE  CAM C word
//  req_valid          out  1          AP request valid
//  req_write          out  1          1 write / 0 read
//  req_addr           out  AW         CAM address (A=0, B=2*CQ, C=4*CQ)
//  settings_write_en  out  1          settings register write strobe
//  settings_addr      out  AW         SET=6*CQ (mode), SET+4 (ctrl)
//  req_wdata          out  32         write data
//  resp               in   32         AP response, combinational in request cycle
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except timeout_err cleared; counters 0.
//  Element index i counts 0..job_count-1; job_count latched at start.
//  IDLE: start=1 -> latch job, clear timeout_err, busy=1, i=0 -> LOAD_A.
//  LOAD_A: in_ready=1; on in_valid: req_valid=1, write, addr=i, wdata=a (zero-ext);
//    capture b -> LOAD_B. No handshake -> stay, req_valid=0.
//  LOAD_B: req write addr=2*CQ+i, wdata=b; i==count-1 -> CFG_MODE, i=0; else i++ -> LOAD_A.
//  CFG_MODE: settings_write_en=1, addr=SET, wdata={8'd0,8'd0,7'd0,dir,5'd0,cmd} -> CFG_CTRL.
//  CFG_CTRL: settings_write_en=1, addr=SET+4, wdata={8'd1,7'd0,target,8'd1,8'd0}
//    (if_state=1, trigger=1, rst=0) -> POLL, poll counter=0.
//  POLL: req_valid=1 read addr=SET+8 every cycle; resp[0]=1 -> CLR;
//    counter==POLL_TIMEOUT-1 -> timeout_err=1 -> CLR (results not drained -> DONE after CLR).
//  CLR: settings write SET+4 wdata=0 (if_state=0, trigger=0) -> DRAIN_RD (or DONE on timeout).
//  DRAIN_RD: req read addr=4*CQ+i; register resp[WORD_SIZE-1:0] into out_data,
//    out_valid=1 next cycle -> DRAIN_OUT.
//  DRAIN_OUT: hold out_data/out_valid stable until out_ready; on handshake
//    i==count-1 -> DONE else i++ -> DRAIN_RD. No req_valid in this state.
//  DONE: done=1 one cycle, busy=0 next -> IDLE.
//  Exactly one of req_valid/settings_write_en high per cycle; never both.
//  start while busy ignored. job_count=0 treated as CELL_QUANT. Indices never wrap.
//  Reset mid-job: immediate IDLE, streams dropped, no settings cleanup write issued.
//  Throughput: LOAD 2 cycles/element minimum; DRAIN 2 cycles/element with out_ready=1.
// TESTING
//  count=3, in {b,a}=0x0201,0x0403,0x0605 always valid -> writes A[0..2]=1,3,5,
//    B[256..258]=2,4,6 (CQ=128), then SET=768 wdata=cmd, SET+4 wdata=0x01000100.
//  Model AP raises resp[0] after 10 polls -> exactly 10 reads of addr 776, one CLR write 0.
//  C memory 0xAA,0xBB,0xCC, out_ready toggled 1/0 -> out_data 0xAA,0xBB,0xCC in order,
//    each held stable while stalled; done pulses once; busy low afterwards.
//  POLL_TIMEOUT=16, resp[0] never set -> timeout_err=1 after 16 polls, CLR write, no out_valid, done.
//  start pulse during DRAIN -> ignored; reset asserted in LOAD_B -> next cycle all outputs 0, IDLE.
//  count=CELL_QUANT -> last writes A[127], B[383]; last read C[639]; no index wrap.

Source files
------------

// File: rtl/ap_host_sequencer.sv
// Host-side job sequencer for the AP wrapper: loads CAM A/B operands, programs and
// triggers the AP, polls for completion, then streams CAM C results out.
module ap_host_sequencer #(
  parameter int  WORD_SIZE    = 8,
  parameter int  CELL_QUANT   = 128,
  parameter int  POLL_TIMEOUT = 4096,
  localparam int AW           = $clog2(CELL_QUANT * 6),
  localparam int CW           = $clog2(CELL_QUANT + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             job_cmd,
  input  logic                   job_dir,
  input  logic                   job_target,
  input  logic [CW-1:0]          job_count,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*WORD_SIZE-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE-1:0]   out_data,
  output logic                   req_valid,
  output logic                   req_write,
  output logic [AW-1:0]          req_addr,
  output logic                   settings_write_en,
  output logic [AW-1:0]          settings_addr,
  output logic [31:0]            req_wdata,
  input  logic [31:0]            resp,
  output logic [3:0]             dbg_state
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [AW-1:0] B_BASE   = AW'(2 * CELL_QUANT);
  localparam logic [AW-1:0] C_BASE   = AW'(4 * CELL_QUANT);
  localparam logic [AW-1:0] SET_BASE = AW'(6 * CELL_QUANT);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, CFG_MODE, CFG_CTRL, POLL, CLR, DRAIN_RD, DRAIN_OUT, DONE
  } state_t;

  state_t                 state;
  logic [CW-1:0]          idx;
  logic [CW-1:0]          count_q;
  logic [WORD_SIZE-1:0]   b_q;
  logic [PW-1:0]          poll_cnt;
  logic [2:0]             cmd_q;
  logic                   dir_q;
  logic                   target_q;
  logic                   last_elem;
  logic                   unused_resp;

  assign last_elem   = (idx == count_q - CW'(1));
  assign dbg_state   = state;
  assign unused_resp = ^resp[31:WORD_SIZE];

  // Streams: a beat transfers on a cycle with valid && ready; a raised valid holds
  // its data stable until that transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      count_q     <= '0;
      b_q         <= '0;
      poll_cnt    <= '0;
      cmd_q       <= '0;
      dir_q       <= 1'b0;
      target_q    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          cmd_q       <= job_cmd;
          dir_q       <= job_dir;
          target_q    <= job_target;
          count_q     <= (job_count == '0) ? CW'(CELL_QUANT) : job_count;
          timeout_err <= 1'b0;
          busy        <= 1'b1;
          idx         <= '0;
          state       <= LOAD_A;
        end
        LOAD_A: if (in_valid) begin
          b_q   <= in_data[2*WORD_SIZE-1:WORD_SIZE];
          state <= LOAD_B;
        end
        LOAD_B: begin
          if (last_elem) begin
            idx   <= '0;
            state <= CFG_MODE;
          end else begin
            idx   <= idx + CW'(1);
            state <= LOAD_A;
          end
        end
        CFG_MODE: state <= CFG_CTRL;
        CFG_CTRL: begin
          poll_cnt <= '0;
          state    <= POLL;
        end
        POLL: begin
          if (resp[0]) begin
            state <= CLR;
          end else if (poll_cnt == PW'(POLL_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= CLR;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end
        // A timed-out job skips draining: CAM C contents are not meaningful.
        CLR: begin
          if (timeout_err) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= DRAIN_RD;
          end
        end
        DRAIN_RD: begin
          out_data  <= resp[WORD_SIZE-1:0];
          out_valid <= 1'b1;
          state     <= DRAIN_OUT;
        end
        DRAIN_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (last_elem) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + CW'(1);
            state <= DRAIN_RD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request-side strobes are decoded from state; LOAD_A forwards the operand
  // in the same cycle as the input handshake.
  always_comb begin
    in_ready          = 1'b0;
    req_valid         = 1'b0;
    req_write         = 1'b0;
    req_addr          = '0;
    settings_write_en = 1'b0;
    settings_addr     = '0;
    req_wdata         = '0;
    unique case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          req_valid = 1'b1;
          req_write = 1'b1;
          req_addr  = AW'(idx);
          req_wdata = 32'(in_data[WORD_SIZE-1:0]);
        end
      end
      LOAD_B: begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = B_BASE + AW'(idx);
        req_wdata = 32'(b_q);
      end
      CFG_MODE: begin
        settings_write_en = 1'b1;
        settings_addr     = SET_BASE;
        req_wdata         = {16'd0, 7'd0, dir_q, 5'd0, cmd_q};
      end
      CFG_CTRL: begin
        settings_write_en = 1'b1;
        settings_addr     = SET_BASE + AW'(4);
        req_wdata         = {8'd1, 7'd0, target_q, 8'd1, 8'd0};
      end
      POLL: begin
        req_valid = 1'b1;
        req_addr  = SET_BASE + AW'(8);
      end
      CLR: begin
        settings_write_en = 1'b1;
        settings_addr     = SET_BASE + AW'(4);
      end
      DRAIN_RD: begin
        req_valid = 1'b1;
        req_addr  = C_BASE + AW'(idx);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ap_host_sequencer.sv
// Directed bench for ap_host_sequencer with a behavioural AP model (poll status
// and CAM C read data) and scoreboards for writes and the result stream.
module tb_ap_host_sequencer;

  localparam int WS = 8;
  localparam int CQ = 128;
  localparam int PT = 16;
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD_B    = 4'd2;
  localparam logic [3:0] S_DRAIN_OUT = 4'd8;

  logic        clock, reset, start;
  logic [2:0]  job_cmd;
  logic        job_dir, job_target;
  logic [7:0]  job_count;
  logic        busy, done, timeout_err;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        req_valid, req_write, settings_write_en;
  logic [9:0]  req_addr, settings_addr;
  logic [31:0] req_wdata, resp;
  logic [3:0]  dbg_state;

  ap_host_sequencer #(.WORD_SIZE(WS), .CELL_QUANT(CQ), .POLL_TIMEOUT(PT)) dut (
    .clock(clock), .reset(reset), .start(start), .job_cmd(job_cmd), .job_dir(job_dir),
    .job_target(job_target), .job_count(job_count), .busy(busy), .done(done),
    .timeout_err(timeout_err), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .settings_write_en(settings_write_en), .settings_addr(settings_addr),
    .req_wdata(req_wdata), .resp(resp), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // AP model: poll status goes high on the ready_after-th poll; CAM C from cmem.
  logic [7:0] cmem [0:CQ-1];
  int poll_seen, ready_after, c_idx;
  always_comb begin
    resp  = '0;
    c_idx = 0;
    if (req_valid && !req_write) begin
      if (req_addr == 10'd776) begin
        resp[0] = (poll_seen >= ready_after);
      end else if (req_addr >= 10'd512 && req_addr < 10'd640) begin
        c_idx     = int'(req_addr) - 512;
        resp[7:0] = cmem[c_idx];
      end
    end
  end

  // Scoreboard: {is_settings, addr, wdata}
  logic [42:0] exp_q[$];
  logic [42:0] act_q[$];
  logic [7:0]  out_exp_q[$];
  logic [7:0]  out_act_q[$];
  int done_cnt, both_cnt, stall_bad, outv_cycles, last_c_addr;

  function automatic logic [42:0] wr(input logic s, input int addr, input logic [31:0] d);
    return {s, addr[9:0], d};
  endfunction

  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (req_valid && settings_write_en) both_cnt++;
        if (req_valid && req_write) act_q.push_back({1'b0, req_addr, req_wdata});
        if (settings_write_en) act_q.push_back({1'b1, settings_addr, req_wdata});
        if (req_valid && !req_write && req_addr == 10'd776) poll_seen++;
        if (req_valid && !req_write && req_addr >= 10'd512 && req_addr < 10'd640)
          last_c_addr = int'(req_addr);
        if (out_valid) outv_cycles++;
        if (out_valid && out_ready) out_act_q.push_back(out_data);
        if (prev_stall && !(out_valid && out_data == prev_data)) stall_bad++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (done) done_cnt++;
      end
    end
  end

  // Driver: operand stream, popped on each observed handshake
  logic [15:0] in_vals[$];
  initial begin
    logic fire;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clock);
      fire = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (fire && in_vals.size() > 0) void'(in_vals.pop_front());
      in_valid = (in_vals.size() > 0);
      in_data  = in_valid ? in_vals[0] : 16'h0;
    end
  end

  // Driver: result stream ready, either constant 1 or toggling
  bit toggle_mode;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      out_ready = toggle_mode ? ~out_ready : 1'b1;
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    act_q.delete();
    out_exp_q.delete();
    out_act_q.delete();
    poll_seen   = 0;
    done_cnt    = 0;
    both_cnt    = 0;
    stall_bad   = 0;
    outv_cycles = 0;
    last_c_addr = -1;
  endtask

  task automatic start_job(input logic [2:0] cmd, input logic dir, input logic tgt,
                           input logic [7:0] cnt);
    @(posedge clock);
    #1;
    job_cmd    = cmd;
    job_dir    = dir;
    job_target = tgt;
    job_count  = cnt;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; optionally pulses start in DRAIN_OUT.
  task automatic wait_done(input string tag, input int budget, input bit poke_drain);
    bit ok, poked, pending;
    ok = 0; poked = 0; pending = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (pending) begin
        start   = 1'b0;
        pending = 0;
      end
      if (done) begin
        ok = 1;
        break;
      end
      if (poke_drain && !poked && dbg_state == S_DRAIN_OUT) begin
        job_count = 8'd5;
        start     = 1'b1;
        poked     = 1;
        pending   = 1;
      end
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, ok, 1);
  endtask

  task automatic compare_sb(input string tag);
    check_eq({tag, "_wr_count"}, act_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++)
      check_eq($sformatf("%s_wr%0d", tag, k), act_q[k], exp_q[k]);
    check_eq({tag, "_out_count"}, out_act_q.size(), out_exp_q.size());
    for (int k = 0; k < out_exp_q.size() && k < out_act_q.size(); k++)
      check_eq($sformatf("%s_out%0d", tag, k), out_act_q[k], out_exp_q[k]);
    check_eq({tag, "_both_strobes"}, both_cnt, 0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; job_cmd = '0; job_dir = 1'b0; job_target = 1'b0;
    job_count = '0; toggle_mode = 0; ready_after = 1000;
    for (int k = 0; k < CQ; k++) cmem[k] = 8'h00;
    clear_sb();

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_req", {req_valid, settings_write_en}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Test A: three elements, toggling out_ready, start poked during drain
    clear_sb();
    toggle_mode = 1; ready_after = 10;
    cmem[0] = 8'hAA; cmem[1] = 8'hBB; cmem[2] = 8'hCC;
    in_vals = '{16'h0201, 16'h0403, 16'h0605};
    exp_q = '{wr(0, 0, 1), wr(0, 256, 2), wr(0, 1, 3), wr(0, 257, 4), wr(0, 2, 5),
              wr(0, 258, 6), wr(1, 768, 32'h5), wr(1, 772, 32'h01000100), wr(1, 772, 0)};
    out_exp_q = '{8'hAA, 8'hBB, 8'hCC};
    start_job(3'd5, 1'b0, 1'b0, 8'd3);
    @(negedge clock);
    check_eq("a_busy_after_start", busy, 1);
    wait_done("a", 400, 1);
    check_eq("a_busy_in_done", busy, 1);
    @(negedge clock);
    check_eq("a_busy_after_done", busy, 0);
    check_eq("a_state_idle", dbg_state, S_IDLE);
    repeat (4) @(negedge clock);
    check_eq("a_start_ignored_idle", {busy, dbg_state}, {1'b0, S_IDLE});
    check_eq("a_done_pulses", done_cnt, 1);
    check_eq("a_polls", poll_seen, 10);
    check_eq("a_stall_stable", stall_bad, 0);
    check_eq("a_timeout", timeout_err, 0);
    compare_sb("a");

    // Test B: poll timeout, horizontal, target A
    clear_sb();
    toggle_mode = 0; ready_after = 1000;
    in_vals = '{16'h1111};
    exp_q = '{wr(0, 0, 32'h11), wr(0, 256, 32'h11), wr(1, 768, 32'h102),
              wr(1, 772, 32'h01010100), wr(1, 772, 0)};
    start_job(3'd2, 1'b1, 1'b1, 8'd1);
    wait_done("b", 200, 0);
    @(negedge clock);
    check_eq("b_polls", poll_seen, PT);
    check_eq("b_timeout_err", timeout_err, 1);
    check_eq("b_no_out_valid", outv_cycles, 0);
    check_eq("b_done_pulses", done_cnt, 1);
    check_eq("b_busy_after", busy, 0);
    compare_sb("b");

    // Test C: reset asserted in LOAD_B
    clear_sb();
    in_vals = '{16'h0A0B, 16'h0C0D};
    start_job(3'd1, 1'b0, 1'b0, 8'd2);
    @(negedge clock);
    check_eq("c_timeout_cleared", timeout_err, 0);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (dbg_state == S_LOAD_B) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    check_eq("c_reached_load_b", seen, 1);
    reset = 1'b1;
    in_vals.delete();
    @(posedge clock);
    #1;
    check_eq("c_rst_state", dbg_state, S_IDLE);
    check_eq("c_rst_outputs", {busy, done, timeout_err, in_ready, out_valid, req_valid,
                               settings_write_en}, 0);
    check_eq("c_rst_buses", {req_addr, settings_addr, req_wdata}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (5) @(negedge clock);
    seen = 0;
    foreach (act_q[k]) if (act_q[k][42]) seen = 1;
    check_eq("c_no_settings_write", seen, 0);
    check_eq("c_still_idle", {busy, dbg_state}, {1'b0, S_IDLE});

    // Test D: job_count=0 means CELL_QUANT; full-range addressing
    clear_sb();
    toggle_mode = 0; ready_after = 1;
    for (int k = 0; k < CQ; k++) begin
      in_vals.push_back({8'(255 - k), 8'(k)});
      cmem[k] = 8'(k * 3 + 7);
      out_exp_q.push_back(8'(k * 3 + 7));
    end
    for (int k = 0; k < CQ; k++) begin
      exp_q.push_back(wr(0, k, 32'(k)));
      exp_q.push_back(wr(0, 256 + k, 32'(255 - k)));
    end
    exp_q.push_back(wr(1, 768, 32'h7));
    exp_q.push_back(wr(1, 772, 32'h01000100));
    exp_q.push_back(wr(1, 772, 0));
    start_job(3'd7, 1'b0, 1'b0, 8'd0);
    wait_done("d", 2000, 0);
    @(negedge clock);
    check_eq("d_last_c_addr", last_c_addr, 639);
    check_eq("d_polls", poll_seen, 1);
    check_eq("d_done_pulses", done_cnt, 1);
    compare_sb("d");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
